// File: rtl/reg16_arb_pkg.sv
// reg16_arb_pkg: shared state encoding, requester limit and owner-width helper for the write arbiter
package reg16_arb_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    localparam int MAX_REQ = 8;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker searching cyclically from last_i+1
module rr_pick
    import reg16_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int OW = owner_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [OW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [OW-1:0] idx_o
);

    logic found;
    int   pos;

    // First requester found after last_i wins; last_i itself is tried last
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last_i) + k) % N;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = OW'(pos);
            end
        end
    end

endmodule

// File: rtl/reg16_write_arbiter.sv
// reg16_write_arbiter: round-robin arbiter for a byte-enabled register write port; REG16_ARB_LOCK_EN enables lock/HOLD
module reg16_write_arbiter
    import reg16_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 16,
    localparam int BE_W    = DATA_W / 8,
    localparam int OW      = owner_w(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    input  logic [NUM_REQ*BE_W-1:0]   wbe,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         reg_d,
    output logic [BE_W-1:0]           reg_byteenable,
    output logic                      busy,
    output logic [OW-1:0]             owner
);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]    reg_d_q, reg_d_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   pick_req, gnt;
    logic [OW-1:0]        idx;

    // WRITE never arbitrates so a granted requester gets a cycle to drop req; HOLD only sees the owner
    assign pick_req = (state_q == IDLE) ? req :
                      (state_q == HOLD) ? (req & (NUM_REQ'(1) << owner_q)) : '0;

    rr_pick #(.N(NUM_REQ), .OW(OW)) u_pick (
        .req_i  (pick_req),
        .last_i (owner_q),
        .gnt_o  (gnt),
        .idx_o  (idx)
    );

    // Next-state: issue a one-cycle write on grant, otherwise strobe and ack fall back to zero
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        be_d    = '0;
        reg_d_d = reg_d_q;
        owner_d = owner_q;
        if (state_q == WRITE) begin
`ifdef REG16_ARB_LOCK_EN
            state_d = lock[owner_q] ? HOLD : IDLE;
`else
            state_d = IDLE;
`endif
        end else if (|pick_req) begin
            state_d = WRITE;
            ack_d   = gnt;
            be_d    = wbe[idx*BE_W +: BE_W];
            reg_d_d = wdata[idx*DATA_W +: DATA_W];
            owner_d = idx;
        end else begin
            state_d = (state_q == HOLD && lock[owner_q]) ? HOLD : IDLE;
        end
    end

    // State and output registers; reset aborts any write in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= '0;
            reg_d_q <= '0;
            be_q    <= '0;
            owner_q <= OW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            reg_d_q <= reg_d_d;
            be_q    <= be_d;
            owner_q <= owner_d;
        end
    end

    assign ack            = ack_q;
    assign reg_d          = reg_d_q;
    assign reg_byteenable = be_q;
    assign busy           = (state_q != IDLE);
    assign owner          = owner_q;

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// tb_reg16_write_arbiter: directed table, corner sequences and randomized model check of reg16_write_arbiter
module tb_reg16_write_arbiter;

`ifdef REG16_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [3:0]  lock  = '0;
    logic [63:0] wdata = {16'h3333, 16'h2222, 16'h1111, 16'hA55A};
    logic [7:0]  wbe   = 8'hFF;
    logic [3:0]  ack;
    logic [15:0] reg_d;
    logic [1:0]  reg_byteenable;
    logic        busy;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    reg16_write_arbiter #(.NUM_REQ(4), .DATA_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .lock           (lock),
        .wdata          (wdata),
        .wbe            (wbe),
        .ack            (ack),
        .reg_d          (reg_d),
        .reg_byteenable (reg_byteenable),
        .busy           (busy),
        .owner          (owner)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  wbe;
        logic [3:0]  ack;
        logic [1:0]  be;
        logic [15:0] d;
        logic [1:0]  own;
        logic        busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        wbe   = 8'hFF;
        wdata = {16'h3333, 16'h2222, 16'h1111, 16'hA55A};
        step();
        reset = 1'b0;
    endtask

    // Reference model: who may be served and when, from the arbitration rules
    int         m_owner;
    bit         m_wrote, m_hold;
    logic [3:0] m_ack;
    logic [1:0] m_be;
    logic [15:0] m_d;

    task automatic model_reset();
        m_owner = 3; m_wrote = 0; m_hold = 0; m_ack = '0; m_be = '0; m_d = '0;
    endtask

    task automatic model_edge();
        logic [3:0] elig;
        int win;
        m_ack = '0;
        m_be  = '0;
        if (m_wrote) begin
            m_wrote = 0;
            m_hold  = LOCK && lock[m_owner];
        end else begin
            elig = m_hold ? (req & (4'b0001 << m_owner)) : req;
            if (elig != 0) begin
                win = -1;
                for (int k = 1; k <= 4; k++)
                    if (win < 0 && elig[(m_owner + k) % 4]) win = (m_owner + k) % 4;
                m_ack[win] = 1'b1;
                m_be    = wbe[win*2 +: 2];
                m_d     = wdata[win*16 +: 16];
                m_owner = win;
                m_wrote = 1;
            end else if (m_hold && !lock[m_owner]) begin
                m_hold = 0;
            end
        end
    endtask

    int got[$];
    int want[$];

    initial begin
        tbl[0]  = '{4'b0001, 8'hFF, 4'b0001, 2'b11, 16'hA55A, 2'd0, 1'b1};
        tbl[1]  = '{4'b0000, 8'hFF, 4'b0000, 2'b00, 16'hA55A, 2'd0, 1'b0};
        tbl[2]  = '{4'b0100, 8'hEF, 4'b0100, 2'b10, 16'h2222, 2'd2, 1'b1};
        tbl[3]  = '{4'b0000, 8'hFF, 4'b0000, 2'b00, 16'h2222, 2'd2, 1'b0};
        tbl[4]  = '{4'b0000, 8'hFF, 4'b0000, 2'b00, 16'h2222, 2'd2, 1'b0};
        tbl[5]  = '{4'b1111, 8'hFF, 4'b1000, 2'b11, 16'h3333, 2'd3, 1'b1};
        tbl[6]  = '{4'b0111, 8'hFF, 4'b0000, 2'b00, 16'h3333, 2'd3, 1'b0};
        tbl[7]  = '{4'b1111, 8'hFF, 4'b0001, 2'b11, 16'hA55A, 2'd0, 1'b1};
        tbl[8]  = '{4'b1110, 8'hFF, 4'b0000, 2'b00, 16'hA55A, 2'd0, 1'b0};
        tbl[9]  = '{4'b1111, 8'hFF, 4'b0010, 2'b11, 16'h1111, 2'd1, 1'b1};
        tbl[10] = '{4'b1101, 8'hFF, 4'b0000, 2'b00, 16'h1111, 2'd1, 1'b0};
        tbl[11] = '{4'b1111, 8'hFF, 4'b0100, 2'b11, 16'h2222, 2'd2, 1'b1};
        tbl[12] = '{4'b1011, 8'hFF, 4'b0000, 2'b00, 16'h2222, 2'd2, 1'b0};
        tbl[13] = '{4'b1011, 8'h3F, 4'b1000, 2'b00, 16'h3333, 2'd3, 1'b1};

        #1;
        step();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_be", 32'(reg_byteenable), 0);
        chk("rst_d", 32'(reg_d), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 3);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req = tbl[i].req;
            wbe = tbl[i].wbe;
            step();
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_be", i), 32'(reg_byteenable), 32'(tbl[i].be));
            chk($sformatf("tbl%0d_d", i), 32'(reg_d), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_own", i), 32'(owner), 32'(tbl[i].own));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        do_reset();
        got.delete();
        for (int i = 0; i < 8; i++) begin
            req  = (i < 6) ? 4'b1010 : 4'b1000;
            lock = (i < 6) ? 4'b0010 : 4'b0000;
            step();
            for (int k = 0; k < 4; k++) if (ack[k]) got.push_back(k);
        end
        want = LOCK ? '{1, 1, 1, 3} : '{1, 3, 1, 3};
        chk("lock_count", 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++)
            chk($sformatf("lock_order%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(want[i]));

        do_reset();
        req = 4'b0001;
        step();
        chk("abort_pre_ack", 32'(ack), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_ack", 32'(ack), 0);
        chk("abort_be", 32'(reg_byteenable), 0);
        chk("abort_owner", 32'(owner), 3);
        chk("abort_busy", 32'(busy), 0);
        #1 reset = 1'b0;
        step();
        chk("regrant_ack", 32'(ack), 1);
        chk("regrant_owner", 32'(owner), 0);

        do_reset();
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            req   = 4'($urandom);
            lock  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            wbe   = 8'($urandom);
            wdata = {$urandom, $urandom};
            @(posedge clock);
            model_edge();
            #1;
            chk("rnd_ack", 32'(ack), 32'(m_ack));
            chk("rnd_be", 32'(reg_byteenable), 32'(m_be));
            chk("rnd_d", 32'(reg_d), 32'(m_d));
            chk("rnd_owner", 32'(owner), 32'(m_owner));
            chk("rnd_busy", 32'(busy), 32'(m_wrote | m_hold));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg16_write_arbiter.md
# reg16_write_arbiter

Round-robin write arbiter that shares the byte-enabled write port of a 16-bit register block among several Avalon-style requesters. Each requester presents data, byte enables and a request. The arbiter grants one requester at a time and drives that requester's write onto the register port for exactly one cycle, then returns a one-cycle acknowledge. It sits between the Qsys-side requesters and the register's first write port. The second port stays dedicated to its own master.

## Interface
- NUM_REQ, 4: number of requesters, legal range 2..8
- DATA_W, 16: register width, multiple of 8
- BE_W, DATA_W/8: byte-enable width (derived, do not override)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level
- lock  in  NUM_REQ  per-requester ownership hold (used only with REG16_ARB_LOCK_EN)
- wdata  in  NUM_REQ*DATA_W  requester i's data at slice [i*DATA_W +: DATA_W]
- wbe  in  NUM_REQ*BE_W  requester i's byte enables at slice [i*BE_W +: BE_W]
- ack  out  NUM_REQ  one-cycle write-done pulse, one-hot or zero
- reg_d  out  DATA_W  data to the register write port
- reg_byteenable  out  BE_W  byte enables to the register write port; all-zero means no write
- busy  out  1  high while in WRITE or HOLD
- owner  out  clog2(NUM_REQ)  index of the last or current grantee

## Operation
- States: IDLE, WRITE, HOLD.
- IDLE: if any req bit is high, pick a winner by round-robin, searching cyclically from owner+1. Register the winner's wdata and wbe into reg_d and reg_byteenable, set ack[winner], load owner with the winner, and go to WRITE. If no req bit is high, stay in IDLE with reg_byteenable = 0.
- WRITE lasts exactly one cycle. reg_byteenable and ack are valid during it. On exit, reg_byteenable and ack are cleared.
  - Go to HOLD if lock[owner] is high (LOCK_EN only).
  - Otherwise go to IDLE.
- WRITE does not arbitrate. This gives the granted requester one cycle to drop req, so a single request is never served twice.
- HOLD: only the owner is eligible.
  - req[owner] high: issue a write as from IDLE, then go to WRITE.
  - req[owner] low and lock[owner] low: go to IDLE.
  - Otherwise stay in HOLD.
- Requester rules:
  - Hold wdata and wbe stable while req is high.
  - Drop req in the cycle after ack (at the next edge) unless another write follows.
- A request with wbe = 0 is still granted and acknowledged. The register is left unchanged.
- reg_d is don't-care when reg_byteenable = 0. It holds its last value to save toggles.

## Timing
- Reset values:
  - state IDLE
  - ack 0
  - reg_d 0
  - reg_byteenable 0
  - busy 0
  - owner NUM_REQ-1, so requester 0 wins first
- Latency: req sampled high at edge n. Write strobe and ack are valid in cycle n (after edge n). The register captures the data at edge n+1.
- Throughput: at most one write every 2 cycles, in both locked and unlocked modes.
- Simultaneous requests: the lowest index at or after owner+1, taken cyclically, wins. The others wait, with no starvation beyond NUM_REQ-1 grants.
- A req drop before grant is allowed and is never acknowledged.
- Asserting reset mid-WRITE aborts it:
  - ack and strobe drop immediately.
  - The requester must re-request after reset.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- REG16_ARB_LOCK_EN defined: lock is honoured and the HOLD state exists.
- REG16_ARB_LOCK_EN undefined:
  - lock is ignored and HOLD is unreachable (WRITE always goes to IDLE).
  - Pure round-robin.

## Structure
- Package reg16_arb_pkg holds:
  - the state enum (IDLE, WRITE, HOLD)
  - the MAX_REQ = 8 constant
  - the owner-width function
- Sub-module rr_pick is combinational.
  - Inputs: request vector and last-owner index.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once and reused by IDLE and HOLD with a masked request vector.

## Test plan
- Reset, then req=4'b0001, wdata0=16'hA55A, wbe0=2'b11:
  - ack[0] pulses one cycle after the edge.
  - reg_byteenable=2'b11 and reg_d=16'hA55A for one cycle.
  - owner=0.
- Single requester, req[2] held with wbe2=2'b10, dropped after ack: exactly one ack[2] and one strobe with reg_byteenable=2'b10.
- req=4'b1111 held continuously, each requester dropping and re-raising req after its ack: grant order 0,1,2,3,0, one ack every 2 cycles.
- LOCK_EN: req1 and lock1 high for 3 writes while req3 is also high:
  - Three ack[1] pulses precede any ack[3].
  - After lock1 and req1 drop, ack[3] follows.
- Without LOCK_EN, same stimulus: acks alternate 1,3,1,3.
- Assert reset in the WRITE cycle of a grant to req[0]:
  - ack and reg_byteenable go to 0 immediately, owner=3.
  - After release with req[0] still high, a fresh grant to requester 0 occurs.
